// File: rtl/iob_eth_rx_filt_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet receive front-end.
package iob_eth_defs;

    localparam logic [7:0]  SFD          = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [47:0] BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]  MIDX_BCAST   = 4'd8;
    localparam logic [3:0]  MIDX_PROMISC = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        DEST,
        DATA,
        DROP,
        CHECK,
        DONE
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/iob_eth_rx_filt_crc.sv
// Ethernet CRC-32 accumulator, one byte per enabled cycle, bits taken LSB first.
module iob_eth_crc
    import iob_eth_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        data_en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_d[31] ^ data_i[i]) begin
                crc_d = {crc_d[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_d = {crc_d[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else if (start_i) begin
            crc_q <= CRC_INIT;
        end else if (data_en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/iob_eth_rx_filt.sv
// Ethernet receive front-end: MII/GMII byte assembly, SFD detection, DA filtering,
// byte-wide buffer write port and per-frame status with a valid/ack handshake.
module iob_eth_rx_filt
    import iob_eth_defs::*;
#(
    parameter int DATA_W    = 4,
    parameter int NUM_MAC   = 2,
    parameter int ADDR_W    = 11,
    parameter int MAX_BYTES = 1518,
    parameter int MIN_BYTES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_dv,
    input  logic                    rx_er,
    input  logic [DATA_W-1:0]       rx_data,
    input  logic [48*NUM_MAC-1:0]   mac_addr,
    input  logic [NUM_MAC-1:0]      mac_en,
    input  logic                    bcast_en,
    input  logic                    promisc,
    input  logic                    frame_ack,
    output logic                    wr,
    output logic [ADDR_W-1:0]       addr,
    output logic [7:0]              data,
    output logic                    frame_valid,
    output logic [ADDR_W:0]         frame_len,
    output logic [3:0]              match_idx,
    output logic                    crc_err,
    output logic                    len_err,
    output logic                    phy_err,
    output logic [7:0]              drop_cnt
);

    localparam int            CW      = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_BYTES);
    localparam logic [CW-1:0] MIN_C   = CW'(MIN_BYTES);
    localparam logic [CW-1:0] DA_LAST = CW'(5);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [39:0]         da_q;
    logic [3:0]          match_q;
    logic                ovf_q;
    logic                perr_q;

    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          data_q;
    logic                fv_q;
    logic [CW-1:0]       flen_q;
    logic [3:0]          midx_q;
    logic                crcerr_q;
    logic                lenerr_q;
    logic                phyerr_q;
    logic [7:0]          drop_q;

    logic [7:0]          rx_byte;
    logic                byte_stb;
    logic                sfd_det;
    logic [31:0]         crc_val;
    logic                crc_start;
    logic                crc_en;

    // Byte assembly: MII pairs nibbles with the phase locked at the SFD.
    if (DATA_W == 8) begin : g_gmii
        assign rx_byte  = rx_data;
        assign byte_stb = rx_dv;
    end else begin : g_mii
        logic [3:0] nib_q;
        logic       phase_q;

        assign rx_byte  = {rx_data, nib_q};
        assign byte_stb = rx_dv && phase_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                nib_q   <= 4'h0;
                phase_q <= 1'b0;
            end else if (!rx_dv) begin
                nib_q   <= 4'h0;
                phase_q <= 1'b0;
            end else begin
                nib_q   <= rx_data;
                phase_q <= ((state_q == IDLE || state_q == DONE) && sfd_det) ? 1'b0 : !phase_q;
            end
        end
    end

    assign sfd_det = rx_dv && (rx_byte == SFD);

    logic [47:0]        da_full;
    logic [NUM_MAC-1:0] hit;
    logic               match_ok;
    logic [3:0]         match_code;

    assign da_full = {da_q, rx_byte};

    for (genvar i = 0; i < NUM_MAC; i++) begin : g_cmp
        assign hit[i] = mac_en[i] && (mac_addr[48*i +: 48] == da_full);
    end

    always_comb begin
        match_ok   = 1'b0;
        match_code = 4'd0;
        for (int i = NUM_MAC - 1; i >= 0; i--) begin
            if (hit[i]) begin
                match_ok   = 1'b1;
                match_code = 4'(i);
            end
        end
        if (!match_ok && bcast_en && da_full == BCAST_MAC) begin
            match_ok   = 1'b1;
            match_code = MIDX_BCAST;
        end else if (!match_ok && promisc) begin
            match_ok   = 1'b1;
            match_code = MIDX_PROMISC;
        end
    end

    assign crc_start = (state_q == IDLE);
    assign crc_en    = byte_stb && (state_q == DEST || state_q == DATA);

    iob_eth_crc u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (crc_start),
        .data_en_i (crc_en),
        .data_i    (rx_byte),
        .crc_o     (crc_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            da_q     <= '0;
            match_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            fv_q     <= 1'b0;
            flen_q   <= '0;
            midx_q   <= '0;
            crcerr_q <= 1'b0;
            lenerr_q <= 1'b0;
            phyerr_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sfd_det) begin
                        state_q <= DEST;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        perr_q  <= 1'b0;
                    end
                end
                DEST: begin
                    if (!rx_dv) begin
                        state_q <= IDLE;
                    end else begin
                        if (rx_er) perr_q <= 1'b1;
                        if (byte_stb) begin
                            wr_q   <= 1'b1;
                            addr_q <= cnt_q[ADDR_W-1:0];
                            data_q <= rx_byte;
                            da_q   <= {da_q[31:0], rx_byte};
                            cnt_q  <= cnt_q + 1'b1;
                            if (cnt_q == DA_LAST) begin
                                state_q <= match_ok ? DATA : DROP;
                                match_q <= match_code;
                            end
                        end
                    end
                end
                DATA: begin
                    if (!rx_dv) begin
                        state_q <= CHECK;
                    end else begin
                        if (rx_er) perr_q <= 1'b1;
                        if (byte_stb) begin
                            if (cnt_q < MAX_C) begin
                                wr_q   <= 1'b1;
                                addr_q <= cnt_q[ADDR_W-1:0];
                                data_q <= rx_byte;
                                cnt_q  <= cnt_q + 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end
                end
                CHECK: begin
                    fv_q     <= 1'b1;
                    flen_q   <= cnt_q;
                    crcerr_q <= (crc_val != CRC_RESIDUE);
                    lenerr_q <= ovf_q || (cnt_q < MIN_C);
                    phyerr_q <= perr_q;
                    midx_q   <= match_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (frame_ack) begin
                        fv_q    <= 1'b0;
                        state_q <= IDLE;
                    end else if (sfd_det) begin
                        drop_q  <= sat_inc8(drop_q);
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    // A frame lost while the host still owns the buffer returns to wait for its ack.
                    if (!rx_dv) state_q <= fv_q ? DONE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr          = wr_q;
    assign addr        = addr_q;
    assign data        = data_q;
    assign frame_valid = fv_q;
    assign frame_len   = flen_q;
    assign match_idx   = midx_q;
    assign crc_err     = crcerr_q;
    assign len_err     = lenerr_q;
    assign phy_err     = phyerr_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_iob_eth_rx_filt.sv
// Bench for iob_eth_rx_filt: one MII and one GMII instance, directed and random frames
// checked against a frame-level model (filter rules, reflected CRC-32, length limits).
module tb_iob_eth_rx_filt;

    localparam int NUM_MAC   = 2;
    localparam int ADDR_W    = 11;
    localparam int MAX_BYTES = 1518;
    localparam int MIN_BYTES = 64;
    localparam logic [47:0] MAC0 = 48'h000102030405;
    localparam logic [47:0] MAC1 = 48'h02AABBCCDDEE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic m_dv, m_er, g_dv, g_er;
    logic [3:0] m_rxd;
    logic [7:0] g_rxd;
    logic [48*NUM_MAC-1:0] mac_addr;
    logic [NUM_MAC-1:0] mac_en;
    logic bcast_en, promisc, frame_ack, m_ack, g_ack;
    bit gm;

    logic m_wr, g_wr, m_fv, g_fv, m_crc, g_crc, m_lerr, g_lerr, m_perr, g_perr;
    logic [ADDR_W-1:0] m_addr, g_addr;
    logic [7:0] m_wd, g_wd, m_drop, g_drop;
    logic [ADDR_W:0] m_len, g_len;
    logic [3:0] m_idx, g_idx;

    assign m_ack = frame_ack && !gm;
    assign g_ack = frame_ack && gm;

    iob_eth_rx_filt #(.DATA_W(4), .NUM_MAC(NUM_MAC), .ADDR_W(ADDR_W),
                      .MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES)) u_mii (
        .clk(clk), .rst_n(rst_n), .rx_dv(m_dv), .rx_er(m_er), .rx_data(m_rxd),
        .mac_addr(mac_addr), .mac_en(mac_en), .bcast_en(bcast_en), .promisc(promisc),
        .frame_ack(m_ack), .wr(m_wr), .addr(m_addr), .data(m_wd), .frame_valid(m_fv),
        .frame_len(m_len), .match_idx(m_idx), .crc_err(m_crc), .len_err(m_lerr),
        .phy_err(m_perr), .drop_cnt(m_drop));

    iob_eth_rx_filt #(.DATA_W(8), .NUM_MAC(NUM_MAC), .ADDR_W(ADDR_W),
                      .MAX_BYTES(MAX_BYTES), .MIN_BYTES(MIN_BYTES)) u_gmii (
        .clk(clk), .rst_n(rst_n), .rx_dv(g_dv), .rx_er(g_er), .rx_data(g_rxd),
        .mac_addr(mac_addr), .mac_en(mac_en), .bcast_en(bcast_en), .promisc(promisc),
        .frame_ack(g_ack), .wr(g_wr), .addr(g_addr), .data(g_wd), .frame_valid(g_fv),
        .frame_len(g_len), .match_idx(g_idx), .crc_err(g_crc), .len_err(g_lerr),
        .phy_err(g_perr), .drop_cnt(g_drop));

    logic o_wr, o_fv, o_crc, o_lerr, o_perr;
    logic [ADDR_W-1:0] o_addr;
    logic [7:0] o_wd, o_drop;
    logic [ADDR_W:0] o_len;
    logic [3:0] o_idx;
    assign o_wr   = gm ? g_wr   : m_wr;
    assign o_fv   = gm ? g_fv   : m_fv;
    assign o_crc  = gm ? g_crc  : m_crc;
    assign o_lerr = gm ? g_lerr : m_lerr;
    assign o_perr = gm ? g_perr : m_perr;
    assign o_addr = gm ? g_addr : m_addr;
    assign o_wd   = gm ? g_wd   : m_wd;
    assign o_drop = gm ? g_drop : m_drop;
    assign o_len  = gm ? g_len  : m_len;
    assign o_idx  = gm ? g_idx  : m_idx;

    int checks = 0;
    int fails  = 0;
    logic [7:0] frm[$];
    int wq_addr[$];
    logic [7:0] wq_data[$];

    always @(negedge clk) begin
        if (rst_n && o_wr) begin
            wq_addr.push_back(int'(o_addr));
            wq_data.push_back(o_wd);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_refl(input int n);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] da, input int n);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        while (frm.size() < n - 4) frm.push_back(8'($urandom));
        fcs = ~crc_refl(frm.size());
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    function automatic int model_idx(input logic [47:0] da);
        for (int i = 0; i < NUM_MAC; i++)
            if (mac_en[i] && mac_addr[48*i +: 48] == da) return i;
        if (bcast_en && da == 48'hFFFF_FFFF_FFFF) return 8;
        if (promisc) return 15;
        return -1;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input bit er, input bit ack_last);
        if (gm) begin
            @(negedge clk);
            g_dv = 1'b1; g_rxd = b; g_er = er; frame_ack = ack_last;
        end else begin
            @(negedge clk);
            m_dv = 1'b1; m_rxd = b[3:0]; m_er = er; frame_ack = 1'b0;
            @(negedge clk);
            m_rxd = b[7:4]; m_er = 1'b0; frame_ack = ack_last;
        end
    endtask

    task automatic send_frame(input int er_at, input bit ack_sfd, input int rst_at);
        for (int i = 0; i < 8; i++) drive_byte((i == 7) ? 8'hD5 : 8'h55, 1'b0, ack_sfd && i == 7);
        for (int i = 0; i < frm.size(); i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                rst_n = 1'b0; m_dv = 1'b0; g_dv = 1'b0; m_er = 1'b0; g_er = 1'b0; frame_ack = 1'b0;
                return;
            end
            drive_byte(frm[i], i == er_at, 1'b0);
        end
        @(negedge clk);
        m_dv = 1'b0; g_dv = 1'b0; m_er = 1'b0; g_er = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic wait_fv(output bit got);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            got = o_fv;
        end
    endtask

    task automatic do_ack(input string tag);
        @(negedge clk); frame_ack = 1'b1;
        @(negedge clk); frame_ack = 1'b0;
        chk({tag, "_ack"}, 32'(o_fv), 32'd0);
    endtask

    task automatic run_check(input string tag, input int er_at);
        int n, idx, exp_w, nw, bad;
        bit got, exp_st;
        logic [47:0] da;
        n = frm.size();
        da = '0;
        for (int i = 0; i < 6 && i < n; i++) da = {da[39:0], frm[i]};
        idx = (n >= 6) ? model_idx(da) : -1;
        exp_st = (idx >= 0);
        exp_w = (n < 6) ? n : ((idx < 0) ? 6 : ((n > MAX_BYTES) ? MAX_BYTES : n));
        wq_addr.delete(); wq_data.delete();
        send_frame(er_at, 1'b0, -1);
        wait_fv(got);
        chk({tag, "_valid"}, 32'(got), 32'(exp_st));
        if (got && exp_st) begin
            chk({tag, "_len"}, 32'(o_len), (n > MAX_BYTES) ? MAX_BYTES : n);
            chk({tag, "_idx"}, 32'(o_idx), idx);
            chk({tag, "_crc"}, 32'(o_crc), 32'(crc_refl(n) != 32'hDEBB20E3));
            chk({tag, "_lenerr"}, 32'(o_lerr), 32'(n < MIN_BYTES || n > MAX_BYTES));
            chk({tag, "_phyerr"}, 32'(o_perr), 32'(er_at >= 0 && er_at < n));
        end
        nw = wq_addr.size();
        chk({tag, "_nwr"}, nw, exp_w);
        bad = 0;
        for (int j = 0; j < nw && j < exp_w; j++)
            if (wq_addr[j] != j || wq_data[j] !== frm[j]) bad++;
        chk({tag, "_wdata"}, bad, 0);
        if (got) do_ack(tag);
    endtask

    initial begin
        bit got;
        int n, sel;
        logic [7:0] len_hold;
        rst_n = 1'b0; m_dv = 1'b0; m_er = 1'b0; m_rxd = '0; g_dv = 1'b0; g_er = 1'b0; g_rxd = '0;
        frame_ack = 1'b0; gm = 1'b0; bcast_en = 1'b0; promisc = 1'b0;
        mac_addr = {MAC1, MAC0}; mac_en = 2'b11;
        repeat (3) @(negedge clk);
        chk("rst_m_fv", 32'(m_fv), 0);
        chk("rst_g_fv", 32'(g_fv), 0);
        chk("rst_m_wr", 32'(m_wr), 0);
        chk("rst_g_drop", 32'(g_drop), 0);
        chk("rst_m_len", 32'(m_len), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        build_frame(MAC0, 64);                 run_check("mii64", -1);
        build_frame(MAC0, 64); frm[20] ^= 8'h10; run_check("mii_bad", -1);
        build_frame(48'hFFFF_FFFF_FFFF, 64);   run_check("bc_off", -1);
        bcast_en = 1'b1;
        build_frame(48'hFFFF_FFFF_FFFF, 64);   run_check("bc_on", -1);
        bcast_en = 1'b0;
        mac_addr = {MAC0, MAC0};
        build_frame(MAC0, 70);                 run_check("prio_both", -1);
        mac_en = 2'b10;
        build_frame(MAC0, 70);                 run_check("prio_hi", -1);
        mac_addr = {MAC1, MAC0}; mac_en = 2'b11; promisc = 1'b1;
        build_frame(48'h123456789ABC, 66);     run_check("promisc", -1);
        promisc = 1'b0;
        build_frame(MAC1, 80);                 run_check("rxer", 30);
        build_frame(MAC0, 64); frm = frm[0:2]; run_check("da_abort", -1);

        gm = 1'b1;
        build_frame(MAC0, 1600);               run_check("g_ovf", -1);
        build_frame(MAC1, 40);                 run_check("g_runt", -1);
        build_frame(MAC0, 100);                run_check("g_ok", -1);

        for (int r = 0; r < 8; r++) begin
            gm = 1'($urandom_range(0, 1));
            n = $urandom_range(40, 200);
            sel = $urandom_range(0, 3);
            bcast_en = 1'($urandom_range(0, 1));
            promisc = ($urandom_range(0, 3) == 0);
            case (sel)
                0: build_frame(MAC0, n);
                1: build_frame(MAC1, n);
                2: build_frame(48'hFFFF_FFFF_FFFF, n);
                default: build_frame({16'($urandom), 32'($urandom)}, n);
            endcase
            if ($urandom_range(0, 2) == 0) frm[$urandom_range(6, n - 1)] ^= 8'h01;
            run_check("rnd", ($urandom_range(0, 3) == 0) ? $urandom_range(6, n - 1) : -1);
        end
        bcast_en = 1'b0; promisc = 1'b0;

        gm = 1'b0;
        build_frame(MAC0, 64);
        send_frame(-1, 1'b0, -1);
        wait_fv(got);
        chk("hold_valid", 32'(got), 1);
        len_hold = 8'(o_len);
        build_frame(MAC0, 72);
        wq_addr.delete(); wq_data.delete();
        send_frame(-1, 1'b0, -1);
        repeat (12) @(negedge clk);
        chk("drop_nwr", wq_addr.size(), 0);
        chk("drop_cnt", 32'(o_drop), 1);
        chk("drop_fv", 32'(o_fv), 1);
        chk("drop_len", 32'(o_len), 32'(len_hold));
        do_ack("drop");

        build_frame(MAC0, 64);
        send_frame(-1, 1'b0, -1);
        wait_fv(got);
        chk("coll_valid", 32'(got), 1);
        frm.delete();
        for (int i = 0; i < 20; i++) frm.push_back(8'h00);
        wq_addr.delete(); wq_data.delete();
        send_frame(-1, 1'b1, -1);
        repeat (12) @(negedge clk);
        chk("coll_fv", 32'(o_fv), 0);
        chk("coll_drop", 32'(o_drop), 1);
        chk("coll_nwr", wq_addr.size(), 0);
        build_frame(MAC1, 64);                 run_check("after_coll", -1);

        build_frame(MAC0, 64);
        wq_addr.delete(); wq_data.delete();
        send_frame(-1, 1'b0, 30);
        @(negedge clk);
        chk("rstm_fv", 32'(o_fv), 0);
        chk("rstm_wr", 32'(o_wr), 0);
        chk("rstm_addr", 32'(o_addr), 0);
        chk("rstm_data", 32'(o_wd), 0);
        chk("rstm_len", 32'(o_len), 0);
        chk("rstm_idx", 32'(o_idx), 0);
        chk("rstm_flags", {29'd0, o_crc, o_lerr, o_perr}, 0);
        chk("rstm_drop", 32'(o_drop), 0);
        rst_n = 1'b1;
        wq_addr.delete(); wq_data.delete();
        repeat (30) @(negedge clk);
        chk("rstm_nofv", 32'(o_fv), 0);
        chk("rstm_nowr", wq_addr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
